// File: rtl/dmem_responder.sv
// Word-addressed data RAM responder for the CPU MEM stage, with WAIT_CYCLES stall cycles per access.
// Optional sticky access-error interrupt enabled by defining MEM_ERR_IRQ_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  input  logic        err_clr,
  output logic        err_irq,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [3:0] LOAD_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q;
  logic [31:0] ram_q [0:(1 << ADDR_WIDTH) - 1];

  logic                  req_s, stall_s, ack_s, wr_s, valid_s, we_s;
  logic [31:0]           acc_addr_s, acc_wdata_s;
  logic [ADDR_WIDTH-1:0] idx_s;

  // In IDLE the live bus is the access; afterwards the latched copy rules.
  assign req_s       = mem_ren | mem_wen;
  assign acc_addr_s  = (state_q == IDLE) ? mem_addr : addr_q;
  assign acc_wdata_s = (state_q == IDLE) ? mem_dout : wdata_q;
  assign wr_s        = (state_q == IDLE) ? mem_wen  : wr_q;
  assign valid_s     = ~|acc_addr_s[31:ADDR_WIDTH+2] & ~|acc_addr_s[1:0];
  assign idx_s       = acc_addr_s[ADDR_WIDTH+1:2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    ack_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (WAIT_CYCLES == 0) begin
            ack_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            cnt_d   = LOAD_CNT;
            state_d = (WAIT_CYCLES == 1) ? DONE : BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        ack_s   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Handshake is gated by rst_n so nothing escapes (or commits) during reset.
  assign mem_stall = stall_s & rst_n;
  assign mem_ack   = ack_s & rst_n;
  assign we_s      = mem_ack & wr_s & valid_s;
  assign mem_din   = (mem_ack & ~wr_s & valid_s) ? ram_q[idx_s] : 32'd0;

  // Capture the access when it is first seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
    end else if (state_q == IDLE && req_s) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_dout;
      wr_q    <= mem_wen;
    end else begin
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
      wr_q    <= wr_q;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      ram_q[idx_s] <= acc_wdata_s;
    end
  end

`ifdef MEM_ERR_IRQ_EN
  logic        err_irq_q;
  logic [31:0] err_addr_q;
  logic        err_s;

  assign err_s = mem_ack & ~valid_s;

  // Sticky error flag; the first error address is kept unless cleared in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= 32'd0;
    end else if (err_s) begin
      err_irq_q <= 1'b1;
      if (!err_irq_q || err_clr) begin
        err_addr_q <= acc_addr_s;
      end else begin
        err_addr_q <= err_addr_q;
      end
    end else if (err_clr) begin
      err_irq_q  <= 1'b0;
      err_addr_q <= err_addr_q;
    end else begin
      err_irq_q  <= err_irq_q;
      err_addr_q <= err_addr_q;
    end
  end

  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign err_irq          = 1'b0;
  assign err_addr         = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: WAIT_CYCLES=2 (a), 0 (b) and 3 (c) instances of dmem_responder.
module tb_dmem_responder;

  logic clk;
  logic rst_n, rst_n_c;
  int   n_checks, n_fail;

  logic        ren_a, wen_a, clr_a, ren_b, wen_b, clr_b, ren_c, wen_c, clr_c;
  logic [31:0] addr_a, dout_a, addr_b, dout_b, addr_c, dout_c;
  logic [31:0] din_a, din_b, din_c, eaddr_a, eaddr_b, eaddr_c;
  logic        stall_a, ack_a, irq_a, stall_b, ack_b, irq_b, stall_c, ack_c, irq_c;
  logic        exp_irq;
  logic [31:0] exp_eaddr;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren_a), .mem_wen(wen_a), .mem_addr(addr_a),
    .mem_dout(dout_a), .mem_din(din_a), .mem_stall(stall_a), .mem_ack(ack_a),
    .err_clr(clr_a), .err_irq(irq_a), .err_addr(eaddr_a));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren_b), .mem_wen(wen_b), .mem_addr(addr_b),
    .mem_dout(dout_b), .mem_din(din_b), .mem_stall(stall_b), .mem_ack(ack_b),
    .err_clr(clr_b), .err_irq(irq_b), .err_addr(eaddr_b));

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_c (
    .clk(clk), .rst_n(rst_n_c), .mem_ren(ren_c), .mem_wen(wen_c), .mem_addr(addr_c),
    .mem_dout(dout_c), .mem_din(din_c), .mem_stall(stall_c), .mem_ack(ack_c),
    .err_clr(clr_c), .err_irq(irq_c), .err_addr(eaddr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // WAIT_CYCLES=2 access: stall in T and T+1, ack in T+2; bus scrambled during stall.
  task automatic acc_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] a2, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    wen_a = w; ren_a = r; addr_a = a; dout_a = d;
    @(negedge clk);
    chk({tag, " T stall"}, {31'd0, stall_a}, 32'd1);
    chk({tag, " T ack"}, {31'd0, ack_a}, 32'd0);
    @(posedge clk); #1;
    wen_a = 1'b0; ren_a = 1'b0; addr_a = a2; dout_a = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({tag, " T+1 stall"}, {31'd0, stall_a}, 32'd1);
    chk({tag, " T+1 din"}, din_a, 32'd0);
    @(negedge clk);
    chk({tag, " ack stall"}, {31'd0, stall_a}, 32'd0);
    chk({tag, " ack"}, {31'd0, ack_a}, 32'd1);
    chk({tag, " ack din"}, din_a, exp);
  endtask

  // WAIT_CYCLES=3 access: stall in T..T+2, ack in T+3.
  task automatic acc_c(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    wen_c = w; ren_c = ~w; addr_c = a; dout_c = d;
    @(negedge clk);
    chk({tag, " T stall"}, {31'd0, stall_c}, 32'd1);
    @(posedge clk); #1;
    wen_c = 1'b0; ren_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({tag, " busy stall"}, {31'd0, stall_c}, 32'd1);
      chk({tag, " busy ack"}, {31'd0, ack_c}, 32'd0);
    end
    @(negedge clk);
    chk({tag, " ack"}, {31'd0, ack_c}, 32'd1);
    chk({tag, " ack din"}, din_c, exp);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; rst_n_c = 1'b0;
    {ren_a, wen_a, clr_a, ren_b, wen_b, clr_b, ren_c, wen_c, clr_c} = 9'd0;
    {addr_a, dout_a, addr_b, dout_b, addr_c, dout_c} = {6{32'd0}};
    repeat (2) @(negedge clk);
    chk("rst stall", {29'd0, stall_a, stall_b, stall_c}, 32'd0);
    chk("rst ack", {29'd0, ack_a, ack_b, ack_c}, 32'd0);
    chk("rst din", din_a | din_b | din_c, 32'd0);
    chk("rst err_irq", {29'd0, irq_a, irq_b, irq_c}, 32'd0);
    chk("rst err_addr", eaddr_a | eaddr_b | eaddr_c, 32'd0);
    rst_n = 1'b1; rst_n_c = 1'b1;

    // WAIT_CYCLES=2: basic write/read, latched address, write-priority, bad accesses.
    acc_a(1'b1, 1'b0, 32'h10, 32'h1234_5678, 32'h14, 32'd0, "w2 wr10");
    @(negedge clk);
    chk("w2 idle ack", {31'd0, ack_a}, 32'd0);
    chk("w2 idle din", din_a, 32'd0);
    acc_a(1'b0, 1'b1, 32'h10, 32'd0, 32'h14, 32'h1234_5678, "w2 rd10");
    acc_a(1'b1, 1'b0, 32'h10, 32'h11, 32'h0, 32'd0, "w2 wr11");
    acc_a(1'b1, 1'b0, 32'h14, 32'h22, 32'h0, 32'd0, "w2 wr22");
    acc_a(1'b0, 1'b1, 32'h10, 32'd0, 32'h14, 32'h11, "w2 rd switch");
    acc_a(1'b1, 1'b1, 32'h40, 32'h0000_BEEF, 32'h0, 32'd0, "w2 both");
    acc_a(1'b0, 1'b1, 32'h40, 32'd0, 32'h0, 32'h0000_BEEF, "w2 rd40");
    acc_a(1'b1, 1'b0, 32'h4, 32'h55, 32'h0, 32'd0, "w2 wr04");
    acc_a(1'b0, 1'b1, 32'h1000, 32'd0, 32'h0, 32'd0, "w2 rd bad");
`ifdef MEM_ERR_IRQ_EN
    exp_irq = 1'b1; exp_eaddr = 32'h1000;
`else
    exp_irq = 1'b0; exp_eaddr = 32'd0;
`endif
    @(negedge clk);
    chk("err irq set", {31'd0, irq_a}, {31'd0, exp_irq});
    chk("err addr set", eaddr_a, exp_eaddr);
    acc_a(1'b1, 1'b0, 32'h6, 32'h99, 32'h0, 32'd0, "w2 wr bad");
    @(negedge clk);
    chk("err addr kept", eaddr_a, exp_eaddr);
    chk("err irq kept", {31'd0, irq_a}, {31'd0, exp_irq});
    @(posedge clk); #1; clr_a = 1'b1;
    @(posedge clk); #1; clr_a = 1'b0;
    @(negedge clk);
    chk("err irq clr", {31'd0, irq_a}, 32'd0);
    acc_a(1'b0, 1'b1, 32'h4, 32'd0, 32'h0, 32'h55, "w2 rd04 kept");

    // WAIT_CYCLES=0: single-cycle access, read-after-write.
    @(posedge clk); #1;
    wen_b = 1'b1; addr_b = 32'h20; dout_b = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("w0 wr stall", {31'd0, stall_b}, 32'd0);
    chk("w0 wr ack", {31'd0, ack_b}, 32'd1);
    chk("w0 wr din", din_b, 32'd0);
    @(posedge clk); #1;
    wen_b = 1'b0; ren_b = 1'b1;
    @(negedge clk);
    chk("w0 rd stall", {31'd0, stall_b}, 32'd0);
    chk("w0 rd ack", {31'd0, ack_b}, 32'd1);
    chk("w0 rd din", din_b, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ren_b = 1'b0;
    @(negedge clk);
    chk("w0 idle ack", {31'd0, ack_b}, 32'd0);
    chk("w0 idle din", din_b, 32'd0);

    // WAIT_CYCLES=3: reset in the second stall cycle discards the write.
    acc_c(1'b1, 32'h30, 32'h0BAD_F00D, 32'd0, "w3 wr old");
    @(posedge clk); #1;
    wen_c = 1'b1; addr_c = 32'h30; dout_c = 32'hAAAA_5555;
    @(negedge clk);
    chk("w3 abort T stall", {31'd0, stall_c}, 32'd1);
    @(posedge clk); #1;
    wen_c = 1'b0;
    #2 rst_n_c = 1'b0;
    #1;
    chk("w3 abort stall", {31'd0, stall_c}, 32'd0);
    chk("w3 abort ack", {31'd0, ack_c}, 32'd0);
    chk("w3 abort din", din_c, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("w3 in rst ack", {31'd0, ack_c}, 32'd0);
    end
    rst_n_c = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("w3 post rst ack", {31'd0, ack_c}, 32'd0);
      chk("w3 post rst stall", {31'd0, stall_c}, 32'd0);
    end
    acc_c(1'b0, 32'h30, 32'd0, 32'h0BAD_F00D, "w3 rd old");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
